// File: rtl/multicycle_controller_if.sv
// Memory-port handshake bundle between the multicycle controller (master)
// and the unified instruction/data memory (slave).
interface multicycle_controller_if;
    logic mem_req;
    logic mem_ready;
    logic AdrSrc;
    logic MemWrite;

    modport master (
        output mem_req,
        output AdrSrc,
        output MemWrite,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  AdrSrc,
        input  MemWrite,
        output mem_ready
    );
endinterface

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle RV32I core: sequences ALU, memory port and
// register file. Define MC_CTRL_PERF_EN to add cycle_cnt / instret_cnt counters.
module multicycle_controller (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [6:0]               op,
    input  logic                     zero,
    multicycle_controller_if.master  mem,
    output logic                     IRWrite,
    output logic                     PCWrite,
    output logic                     RegWrite,
    output logic [1:0]               ALUSrcA,
    output logic [1:0]               ALUSrcB,
    output logic [1:0]               ResultSrc,
    output logic [1:0]               ALU_op,
    output logic                     illegal
`ifdef MC_CTRL_PERF_EN
    ,
    output logic [31:0]              cycle_cnt,
    output logic [31:0]              instret_cnt
`endif
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    typedef struct packed {
        logic       mem_req;
        logic       adr_src;
        logic       mem_write;
        logic       reg_write;
        logic       fetch;       // IRWrite/PCWrite follow mem_ready
        logic       beq;         // PCWrite follows zero
        logic       pc_write;    // unconditional PC load
        logic       illegal;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic [1:0] alu_op;
    } ctrl_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    state_t state_reg;
    state_t state_next;
    ctrl_t  ctrl_reg;

    function automatic ctrl_t decode(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_req    = 1'b1;
                c.fetch      = 1'b1;
                c.alu_src_b  = 2'b10;
                c.result_src = 2'b10;
            end
            S_DECODE: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b01;
            end
            S_MEMADR: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
            end
            S_MEMREAD: begin
                c.mem_req = 1'b1;
                c.adr_src = 1'b1;
            end
            S_MEMWB: begin
                c.result_src = 2'b01;
                c.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                c.mem_req   = 1'b1;
                c.mem_write = 1'b1;
                c.adr_src   = 1'b1;
            end
            S_EXECR: begin
                c.alu_src_a = 2'b10;
                c.alu_op    = 2'b10;
            end
            S_EXECI: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
                c.alu_op    = 2'b10;
            end
            S_ALUWB: begin
                c.reg_write = 1'b1;
            end
            S_BEQ: begin
                c.beq       = 1'b1;
                c.alu_src_a = 2'b10;
                c.alu_op    = 2'b01;
            end
            S_JAL: begin
                c.pc_write  = 1'b1;
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b10;
            end
            S_TRAP: begin
                c.illegal = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_FETCH:    if (mem.mem_ready) state_next = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_RTYPE:          state_next = S_EXECR;
                    OP_ITYPE:          state_next = S_EXECI;
                    OP_BRANCH:         state_next = S_BEQ;
                    OP_JAL:            state_next = S_JAL;
                    default:           state_next = S_TRAP;
                endcase
            end
            S_MEMADR:   state_next = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem.mem_ready) state_next = S_MEMWB;
            S_MEMWB:    state_next = S_FETCH;
            S_MEMWRITE: if (mem.mem_ready) state_next = S_FETCH;
            S_EXECR:    state_next = S_ALUWB;
            S_EXECI:    state_next = S_ALUWB;
            S_ALUWB:    state_next = S_FETCH;
            S_BEQ:      state_next = S_FETCH;
            S_JAL:      state_next = S_ALUWB;
            S_TRAP:     state_next = S_TRAP;
            default:    state_next = S_FETCH;
        endcase
    end

    // Control word is registered from the next state, so it always equals the
    // Moore decode of state_reg without a combinational decoder on the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_FETCH;
            ctrl_reg  <= decode(S_FETCH);
        end else begin
            state_reg <= state_next;
            ctrl_reg  <= decode(state_next);
        end
    end

    // Strobes are gated by rst_n so nothing asserts while reset is held, yet
    // mem_req rises in the very first cycle after release.
    assign mem.mem_req  = rst_n & ctrl_reg.mem_req;
    assign mem.MemWrite = rst_n & ctrl_reg.mem_write;
    assign mem.AdrSrc   = ctrl_reg.adr_src;
    assign RegWrite     = rst_n & ctrl_reg.reg_write;
    assign illegal      = rst_n & ctrl_reg.illegal;
    assign IRWrite      = rst_n & ctrl_reg.fetch & mem.mem_ready;
    assign PCWrite      = rst_n & (ctrl_reg.pc_write
                                   | (ctrl_reg.fetch & mem.mem_ready)
                                   | (ctrl_reg.beq & zero));
    assign ALUSrcA      = ctrl_reg.alu_src_a;
    assign ALUSrcB      = ctrl_reg.alu_src_b;
    assign ResultSrc    = ctrl_reg.result_src;
    assign ALU_op       = ctrl_reg.alu_op;

`ifdef MC_CTRL_PERF_EN
    logic [31:0] cycle_cnt_reg;
    logic [31:0] instret_cnt_reg;
    logic        retire;

    // An instruction retires when its last step hands control back to FETCH.
    assign retire = (state_next == S_FETCH) &&
                    ((state_reg == S_MEMWB) || (state_reg == S_MEMWRITE) ||
                     (state_reg == S_ALUWB) || (state_reg == S_BEQ));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt_reg   <= 32'd0;
            instret_cnt_reg <= 32'd0;
        end else begin
            cycle_cnt_reg <= cycle_cnt_reg + 32'd1;
            if (retire) begin
                instret_cnt_reg <= instret_cnt_reg + 32'd1;
            end
        end
    end

    assign cycle_cnt   = cycle_cnt_reg;
    assign instret_cnt = instret_cnt_reg;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: per-cycle output vectors from
// a stimulus table through a scoreboard queue, plus reset/trap/perf sequences.
module tb_multicycle_controller;

    logic       clk;
    logic       rst_n;
    logic [6:0] op;
    logic       zero;
    logic       IRWrite, PCWrite, RegWrite, illegal;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ALU_op;
`ifdef MC_CTRL_PERF_EN
    logic [31:0] cycle_cnt, instret_cnt;
`endif

    multicycle_controller_if mem_bus ();

    multicycle_controller dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .op        (op),
        .zero      (zero),
        .mem       (mem_bus.master),
        .IRWrite   (IRWrite),
        .PCWrite   (PCWrite),
        .RegWrite  (RegWrite),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ResultSrc (ResultSrc),
        .ALU_op    (ALU_op),
        .illegal   (illegal)
`ifdef MC_CTRL_PERF_EN
        ,
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {mem_req, AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, ALUSrcA, ALUSrcB, ResultSrc, ALU_op, illegal}
    logic [14:0] act;
    assign act = {mem_bus.mem_req, mem_bus.AdrSrc, IRWrite, PCWrite, RegWrite,
                  mem_bus.MemWrite, ALUSrcA, ALUSrcB, ResultSrc, ALU_op, illegal};

    localparam logic [14:0] E_RST    = {6'b000000, 2'b00, 2'b10, 2'b10, 2'b00, 1'b0};
    localparam logic [14:0] E_FETCH  = {6'b101100, 2'b00, 2'b10, 2'b10, 2'b00, 1'b0};
    localparam logic [14:0] E_FETCHW = {6'b100000, 2'b00, 2'b10, 2'b10, 2'b00, 1'b0};
    localparam logic [14:0] E_DEC    = {6'b000000, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0};
    localparam logic [14:0] E_MADR   = {6'b000000, 2'b10, 2'b01, 2'b00, 2'b00, 1'b0};
    localparam logic [14:0] E_MRD    = {6'b110000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [14:0] E_MWB    = {6'b000010, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0};
    localparam logic [14:0] E_MWR    = {6'b110001, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [14:0] E_EXR    = {6'b000000, 2'b10, 2'b00, 2'b00, 2'b10, 1'b0};
    localparam logic [14:0] E_EXI    = {6'b000000, 2'b10, 2'b01, 2'b00, 2'b10, 1'b0};
    localparam logic [14:0] E_AWB    = {6'b000010, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [14:0] E_BEQ1   = {6'b000100, 2'b10, 2'b00, 2'b00, 2'b01, 1'b0};
    localparam logic [14:0] E_BEQ0   = {6'b000000, 2'b10, 2'b00, 2'b00, 2'b01, 1'b0};
    localparam logic [14:0] E_JAL    = {6'b000100, 2'b01, 2'b10, 2'b00, 2'b00, 1'b0};
    localparam logic [14:0] E_TRAP   = {6'b000000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1};

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    typedef struct packed {
        logic [6:0]  op;
        logic        zero;
        logic        ready;
        logic [14:0] exp;
    } vec_t;

    vec_t        tbl[$];
    logic [14:0] exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end else begin
            $display("ok   %s: %h", name, got);
        end
    endtask

    // One cycle: drive at the falling edge, compare 1ns later, advance one clock.
    task automatic step(input string name, input logic [6:0] o, input logic z,
                        input logic r, input logic [14:0] e);
        op                = o;
        zero              = z;
        mem_bus.mem_ready = r;
        exp_q.push_back(e);
        #1;
        check(name, {17'd0, act}, {17'd0, exp_q.pop_front()});
        @(negedge clk);
    endtask

    task automatic add_row(input logic [6:0] o, input logic z, input logic r, input logic [14:0] e);
        vec_t v;
        v.op = o; v.zero = z; v.ready = r; v.exp = e;
        tbl.push_back(v);
    endtask

    task automatic run_table(input string tag);
        foreach (tbl[i]) begin
            step($sformatf("%s[%0d]", tag, i), tbl[i].op, tbl[i].zero, tbl[i].ready, tbl[i].exp);
        end
        tbl.delete();
    endtask

    initial begin
        rst_n             = 1'b0;
        op                = 7'd0;
        zero              = 1'b0;
        mem_bus.mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("reset_outputs", {17'd0, act}, {17'd0, E_RST});
        @(negedge clk);
        rst_n = 1'b1;

`ifdef MC_CTRL_PERF_EN
        // add, lw, beq with no wait states: 4 + 5 + 3 cycles, 3 retirements
        add_row(OP_R,   0, 1, E_FETCH); add_row(OP_R,   0, 1, E_DEC);
        add_row(OP_R,   0, 1, E_EXR);   add_row(OP_R,   0, 1, E_AWB);
        add_row(OP_LW,  0, 1, E_FETCH); add_row(OP_LW,  0, 1, E_DEC);
        add_row(OP_LW,  0, 1, E_MADR);  add_row(OP_LW,  0, 1, E_MRD);
        add_row(OP_LW,  0, 1, E_MWB);
        add_row(OP_BEQ, 0, 1, E_FETCH); add_row(OP_BEQ, 0, 1, E_DEC);
        add_row(OP_BEQ, 1, 1, E_BEQ1);
        run_table("perf");
        check("instret_cnt", instret_cnt, 32'd3);
        check("cycle_cnt", cycle_cnt, 32'd12);
        dut.cycle_cnt_reg = 32'hFFFF_FFFF;
        #1;
        check("cycle_cnt_max", cycle_cnt, 32'hFFFF_FFFF);
        @(negedge clk);
        check("cycle_cnt_wrap", cycle_cnt, 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
`endif

        // R-type add; zero toggled in EXECR must not matter
        add_row(OP_R,   0, 1, E_FETCH); add_row(OP_R,   0, 1, E_DEC);
        add_row(OP_R,   1, 1, E_EXR);   add_row(OP_R,   0, 1, E_AWB);
        // fetch wait state followed by another add
        add_row(OP_R,   0, 0, E_FETCHW); add_row(OP_R,  0, 1, E_FETCH);
        add_row(OP_R,   0, 1, E_DEC);    add_row(OP_R,  0, 1, E_EXR);
        add_row(OP_R,   0, 1, E_AWB);
        // lw with two wait cycles in MEMREAD: 7 cycles
        add_row(OP_LW,  0, 1, E_FETCH); add_row(OP_LW,  0, 1, E_DEC);
        add_row(OP_LW,  1, 1, E_MADR);  add_row(OP_LW,  0, 0, E_MRD);
        add_row(OP_LW,  0, 0, E_MRD);   add_row(OP_LW,  0, 1, E_MRD);
        add_row(OP_LW,  0, 1, E_MWB);
        // beq taken, then not taken
        add_row(OP_BEQ, 0, 1, E_FETCH); add_row(OP_BEQ, 0, 1, E_DEC);
        add_row(OP_BEQ, 1, 1, E_BEQ1);
        add_row(OP_BEQ, 0, 1, E_FETCH); add_row(OP_BEQ, 0, 1, E_DEC);
        add_row(OP_BEQ, 0, 1, E_BEQ0);
        // sw
        add_row(OP_SW,  0, 1, E_FETCH); add_row(OP_SW,  0, 1, E_DEC);
        add_row(OP_SW,  0, 1, E_MADR);  add_row(OP_SW,  0, 1, E_MWR);
        // addi
        add_row(OP_I,   0, 1, E_FETCH); add_row(OP_I,   0, 1, E_DEC);
        add_row(OP_I,   0, 1, E_EXI);   add_row(OP_I,   0, 1, E_AWB);
        // jal
        add_row(OP_JAL, 0, 1, E_FETCH); add_row(OP_JAL, 0, 1, E_DEC);
        add_row(OP_JAL, 0, 1, E_JAL);   add_row(OP_JAL, 0, 1, E_AWB);
        run_table("vec");

        // illegal opcode traps and stays trapped
        step("trap_fetch", OP_BAD, 0, 1, E_FETCH);
        step("trap_decode", OP_BAD, 0, 1, E_DEC);
        for (int i = 0; i < 10; i++) begin
            step($sformatf("trap_hold[%0d]", i), OP_R, 1'b1, 1'b1, E_TRAP);
        end

        // asynchronous reset pulse leaves TRAP for FETCH
        rst_n = 1'b0;
        #1;
        check("trap_reset", {17'd0, act}, {17'd0, E_RST});
        #1;
        rst_n = 1'b1;
        #1;
        check("post_reset_fetch", {17'd0, act}, {17'd0, E_FETCH});
        @(negedge clk);

        // reset in the middle of a stalled store kills MemWrite at once
        step("sw_decode", OP_SW, 0, 1, E_DEC);
        step("sw_madr", OP_SW, 0, 1, E_MADR);
        mem_bus.mem_ready = 1'b0;
        #1;
        check("sw_stall", {17'd0, act}, {17'd0, E_MWR});
        #1;
        rst_n = 1'b0;
        #1;
        check("sw_reset", {17'd0, act}, {17'd0, E_RST});
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("sw_refetch", {17'd0, act}, {17'd0, E_FETCHW});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Main control FSM for the multicycle RV32I core. It sequences one shared ALU, the unified instruction/data memory port and the register file across FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK steps, and drives the 2-bit `ALU_op` consumed by `ALU_Decoder`. Memory accesses use a request/ready handshake, so wait states are inserted without losing control state.

## Interface
Parameters: none.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `op` in 7: `instr[6:0]`, taken from the instruction register.
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory completes the current access this cycle.
- `mem_req` out 1: memory access requested.
- `AdrSrc` out 1: memory address select; 0 = PC, 1 = Result.
- `IRWrite` out 1: load IR and OldPC.
- `PCWrite` out 1: load PC from Result.
- `RegWrite` out 1: register-file write enable.
- `MemWrite` out 1: store strobe, valid with `mem_req`.
- `ALUSrcA` out 2: 00 = PC, 01 = OldPC, 10 = A register.
- `ALUSrcB` out 2: 00 = B register, 01 = ImmExt, 10 = constant 4.
- `ResultSrc` out 2: 00 = ALUOut, 01 = Data register, 10 = ALUResult.
- `ALU_op` out 2: 00 = add, 01 = sub/compare, 10 = decode funct3/funct7.
- `illegal` out 1: unsupported opcode trapped.

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL, TRAP.
- State outputs (outputs not listed are 0/00):
  - FETCH: `mem_req`=1, `AdrSrc`=0, `ALUSrcA`=00, `ALUSrcB`=10, `ALU_op`=00, `ResultSrc`=10. `IRWrite` and `PCWrite` equal `mem_ready`. The state holds until `mem_ready`, then goes to DECODE.
  - DECODE: `ALUSrcA`=01, `ALUSrcB`=01, `ALU_op`=00, used for the branch-target precompute. Next state by `op`:
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXECR
    - 0010011 → EXECI
    - 1100011 → BEQ
    - 1101111 → JAL
    - any other opcode → TRAP
  - MEMADR: `ALUSrcA`=10, `ALUSrcB`=01, `ALU_op`=00. Next is MEMREAD if `op[5]`=0, otherwise MEMWRITE.
  - MEMREAD: `mem_req`=1, `AdrSrc`=1, `ResultSrc`=00. The state holds until `mem_ready`, then goes to MEMWB.
  - MEMWB: `ResultSrc`=01, `RegWrite`=1. Next is FETCH.
  - MEMWRITE: `mem_req`=1, `MemWrite`=1, `AdrSrc`=1, `ResultSrc`=00. The state holds until `mem_ready`, then goes to FETCH.
  - EXECR: `ALUSrcA`=10, `ALUSrcB`=00, `ALU_op`=10. Next is ALUWB.
  - EXECI: `ALUSrcA`=10, `ALUSrcB`=01, `ALU_op`=10. Next is ALUWB.
  - ALUWB: `ResultSrc`=00, `RegWrite`=1. Next is FETCH.
  - BEQ: `ALUSrcA`=10, `ALUSrcB`=00, `ALU_op`=01, `ResultSrc`=00. `PCWrite` equals `zero`. Next is FETCH.
  - JAL: `ALUSrcA`=01, `ALUSrcB`=10, `ALU_op`=00, `ResultSrc`=00, `PCWrite`=1. Next is ALUWB.
  - TRAP: `illegal`=1 and all strobes are 0. The state stays in TRAP until reset.
- Outputs are Moore-decoded from state. The exceptions are `PCWrite` in BEQ (qualified by `zero`) and `IRWrite`/`PCWrite` in FETCH (qualified by `mem_ready`).
- `MemWrite` and `RegWrite` are never 1 in the same cycle.

## Timing
- Reset: while `rst_n`=0, state is FETCH and `mem_req`, `IRWrite`, `PCWrite`, `RegWrite`, `MemWrite` and `illegal` are forced to 0. Mux selects show their FETCH values.
- The first `mem_req` is asserted in the first cycle after `rst_n` deasserts.
- Cycles per instruction with zero wait: lw 5, sw 4, R-type 4, I-ALU 4, beq 3, jal 4.
- Each cycle with `mem_ready`=0 in FETCH, MEMREAD or MEMWRITE adds exactly one cycle.
- `mem_ready` outside a `mem_req` state is ignored.
- Reset asserted mid-instruction returns the FSM to FETCH immediately and asynchronously. No partial write strobe survives.
- A `zero` change in any state other than BEQ has no effect.

## Configuration
- `MC_CTRL_PERF_EN` defined:
  - Adds output `cycle_cnt` (32 bits). It increments every clock while `rst_n`=1.
  - Adds output `instret_cnt` (32 bits). It increments on each transition into FETCH from MEMWB, MEMWRITE, ALUWB or BEQ.
  - Both counters reset to 0 and wrap from 0xFFFFFFFF to 0.
  - TRAP does not increment `instret_cnt`.
- Not defined: neither port nor counter exists, and behaviour is otherwise identical.

## Test plan
- R-type `add` (`op`=0110011), `mem_ready` tied 1 → state sequence FETCH, DECODE, EXECR, ALUWB. `ALU_op`=10 in EXECR. `RegWrite`=1 only in cycle 4.
- lw (`op`=0000011), `mem_ready`=0 for 2 cycles in MEMREAD → 7 cycles total. `AdrSrc`=1 held across the wait. `RegWrite` with `ResultSrc`=01 in the last cycle.
- beq (`op`=1100011) with `zero`=1 → `PCWrite`=1, `ALU_op`=01 in cycle 3. With `zero`=0 → `PCWrite`=0 and next state FETCH.
- sw (`op`=0100011), `mem_ready`=1 → `MemWrite`=`mem_req`=1 in cycle 4 only. `RegWrite` never asserted.
- `op`=1111111 → TRAP after DECODE and `illegal`=1 held for 10 cycles. `rst_n` pulse → FETCH with `illegal`=0.
- `MC_CTRL_PERF_EN`: run add, lw, beq with zero wait → `instret_cnt`=3 and `cycle_cnt`=12. Preload a wrap case → 0xFFFFFFFF then 0.
